// File: rtl/xor32_descrambler_pkg.sv
// Shared constants and state type for the XOR32 descrambler and its transmit-side scrambler twin.
package xor32_descrambler_pkg;

  localparam int          WORD_W            = 32;
  localparam int          CNT_W             = 16;
  localparam logic [31:0] LFSR_POLY         = 32'h04C11DB7;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hFFFFFFFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RESEED = 1'b1
  } ds_state_e;

endpackage

// File: rtl/xor32_descrambler_if.sv
// Valid/ready stream bundle: scrambled words in, descrambled words out.
interface xor32_descrambler_if #(
  parameter int WIDTH = xor32_descrambler_pkg::WORD_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/xor32_descrambler_lfsr32_step.sv
// One Galois LFSR step plus the keystream XOR mask; shared with the transmit-side scrambler.
module lfsr32_step
  import xor32_descrambler_pkg::*;
#(
  parameter int               WIDTH = WORD_W,
  parameter logic [WIDTH-1:0] POLY  = LFSR_POLY
) (
  input  logic [WIDTH-1:0] ks,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] ks_next,
  output logic [WIDTH-1:0] data_masked
);

  assign ks_next     = {ks[WIDTH-2:0], 1'b0} ^ (ks[WIDTH-1] ? POLY : '0);
  assign data_masked = data ^ ks;

endmodule

// File: rtl/xor32_descrambler.sv
// Streaming additive descrambler: XORs each accepted word with a Galois LFSR keystream,
// one registered output stage, reseedable at any time, saturating delivered-word counter.
module xor32_descrambler
  import xor32_descrambler_pkg::*;
#(
  parameter int               WIDTH        = WORD_W,
  parameter logic [WIDTH-1:0] POLY         = LFSR_POLY,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed,
  xor32_descrambler_if.slave   bus,
  output logic [CNT_W-1:0]     word_count
);

  ds_state_e        state;
  logic [WIDTH-1:0] ks;
  logic [WIDTH-1:0] ks_next;
  logic [WIDTH-1:0] masked_p0;
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic             in_hs;
  logic             out_hs;

  // A zero seed would lock the LFSR at zero, so it falls back to the default.
  function automatic logic [WIDTH-1:0] seed_pick(input logic [WIDTH-1:0] s);
    return (s == '0) ? SEED_DEFAULT : s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  lfsr32_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .ks          (ks),
    .data        (bus.in_data),
    .ks_next     (ks_next),
    .data_masked (masked_p0)
  );

  assign bus.in_ready  = (state == ST_RUN) && !seed_load && (!vld_p1 || bus.out_ready);
  assign in_hs         = bus.in_valid && bus.in_ready;
  assign out_hs        = vld_p1 && bus.out_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;

  // Stage p0 -> p1: mask with the current keystream and register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      ks         <= SEED_DEFAULT;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      word_count <= '0;
    end else begin
      case (state)
        ST_RUN:    state <= seed_load ? ST_RESEED : ST_RUN;
        ST_RESEED: state <= seed_load ? ST_RESEED : ST_RUN;
        default:   state <= ST_RUN;
      endcase

      if (seed_load) begin
        ks <= seed_pick(seed);
      end else if (in_hs) begin
        ks <= ks_next;
      end

      if (in_hs) begin
        data_p1 <= masked_p0;
        vld_p1  <= 1'b1;
      end else if (out_hs) begin
        vld_p1  <= 1'b0;
      end

      if (seed_load) begin
        word_count <= '0;
      end else if (out_hs) begin
        word_count <= sat_inc(word_count);
      end
    end
  end

endmodule

// File: tb/tb_xor32_descrambler.sv
// Scoreboard bench for xor32_descrambler: directed vectors with hand-computed results plus
// a reference-scrambler round trip and counter saturation run.
module tb_xor32_descrambler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [31:0] seed;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  int sb_checks = 0;
  int sb_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ref_ks;

  always #5 clk = ~clk;

  xor32_descrambler_if bus ();

  xor32_descrambler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .bus        (bus.slave),
    .word_count (word_count)
  );

  // Reference transmit-side keystream: multiply by x modulo the CRC-32 polynomial.
  function automatic logic [31:0] ref_step(input logic [31:0] x);
    return x[31] ? ((x << 1) ^ 32'h04C11DB7) : (x << 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Output-side monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else if (bus.out_valid && bus.out_ready) begin
      sb_checks++;
      if (exp_q.size() == 0) begin
        sb_errors++;
        $display("FAIL sb_unexpected actual=%08h required=none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          sb_errors++;
          $display("FAIL sb_data actual=%08h required=%08h", bus.out_data, e);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n        = 1'b0;
    seed_load    = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offer one word; push its expected output once the DUT accepts it.
  task automatic send(input logic [31:0] d, input logic [31:0] e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) begin
      exp_q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept_%08h", d);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Feed n words scrambled by the reference; the DUT must return the plaintext.
  task automatic stream(input int n, input bit rnd);
    int          sent;
    int          cyc;
    bit          acc;
    logic [31:0] w;
    sent = 0;
    cyc  = 0;
    w    = $urandom;
    bus.in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.in_data   = w ^ ref_ks;
    bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (sent < n && cyc < n * 8 + 100) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        exp_q.push_back(w);
        ref_ks = ref_step(ref_ks);
        sent++;
        w = $urandom;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc || !bus.in_valid) bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data   = w ^ ref_ks;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.in_valid = 1'b0;
    if (sent < n) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout actual=%0d required=%0d", sent, n);
    end
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    ref_ks = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_word_count", 32'(word_count), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Basic two-word stream from the default seed
    send(32'h12345678, 32'hEDCBA987);
    send(32'h00000000, 32'hFB3EE249);
    repeat (2) @(posedge clk);
    #1 chk("t1_word_count", 32'(word_count), 32'd2);

    // Backpressure: held output, no acceptance, keystream frozen
    do_reset();
    bus.out_ready = 1'b0;
    send(32'h00000000, 32'hFFFFFFFF);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAAAAAAAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_in_ready", 32'(bus.in_ready), 32'h0);
      chk("t2_stall_out_data", bus.out_data, 32'hFFFFFFFF);
    end
    chk("t2_stall_out_valid", 32'(bus.out_valid), 32'h1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(32'hAAAAAAAA, 32'h519448E3);

    // Zero seed falls back to the default; count clear beats same-cycle increment
    seed = 32'h0;
    seed_load = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_load", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk);
    chk("t3_in_ready_reseed", 32'(bus.in_ready), 32'h0);
    chk("t3_word_count_clr", 32'(word_count), 32'h0);
    @(posedge clk);
    #1;
    send(32'h0F0F0F0F, 32'hF0F0F0F0);
    @(posedge clk);
    #1;

    // Reseed under stall: held word keeps old mask, next word uses the new seed
    bus.out_ready = 1'b0;
    send(32'h11111111, 32'hEA2FF358);
    seed = 32'h12345678;
    seed_load = 1'b1;
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk);
    chk("t4_held_data", bus.out_data, 32'hEA2FF358);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(32'h12345678, 32'h00000000);
    repeat (2) @(posedge clk);
    #1 chk("t4_word_count", 32'(word_count), 32'd2);

    // Round trip against the reference scrambler with random handshakes
    seed = 32'hA5A5A5A5;
    seed_load = 1'b1;
    @(posedge clk);
    #1 seed_load = 1'b0;
    ref_ks = 32'hA5A5A5A5;
    stream(1000, 1'b1);
    drain();
    chk("t5_word_count", 32'(word_count), 32'd1000);

    // Asynchronous reset in the middle of a burst
    do_reset();
    send(32'h12345678, 32'hEDCBA987);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000000;
    @(negedge clk);
    chk("t6_in_ready", 32'(bus.in_ready), 32'h1);
    exp_q.push_back(32'hFB3EE249);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_async_out_data", bus.out_data, 32'h0);
    chk("t6_async_word_count", 32'(word_count), 32'h0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'h0000FFFF, 32'hFFFF0000);

    // Counter saturation
    seed = 32'h00000001;
    seed_load = 1'b1;
    @(posedge clk);
    #1 seed_load = 1'b0;
    ref_ks = 32'h00000001;
    stream(70000, 1'b0);
    drain();
    chk("t7_word_count_sat", 32'(word_count), 32'h0000FFFF);

    chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);
    checks += sb_checks;
    errors += sb_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
